// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding scoreboard.
package pipe_pkg;

  localparam int REG_AW = 5;

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] dst;
    logic              is_load;
  } sb_entry_t;

  localparam logic [1:0]        FWD_RF   = 2'd0;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/sb_match.sv
// Finds the youngest in-flight writer of one source register and reports
// whether its result is already available on that stage's result bus.
module sb_match
  import pipe_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic [REG_AW-1:0]         src_addr,
  input  logic                      src_used,
  input  sb_entry_t [DEPTH-1:0]     entries,
  output logic                      hit,
  output logic [1:0]                stage,
  output logic                      ready
);

  // Scan oldest to youngest so the lowest matching stage overwrites the rest.
  always_comb begin
    hit   = 1'b0;
    stage = 2'd0;
    ready = 1'b1;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (src_used && (src_addr != REG_ZERO) && entries[k].vld &&
          (entries[k].dst == src_addr)) begin
        hit   = 1'b1;
        stage = 2'(k);
        ready = !entries[k].is_load || (k >= LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard/forwarding controller: shift-register scoreboard of in-flight writers,
// per-operand forwarding muxes, load-use stall, flush and stall counter.
module pipe_hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_SRC  = 3,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_dst_addr,
  input  logic                      id_dst_wr,
  input  logic                      id_is_load,
  input  logic                      id_redirect,
  input  logic                      ex_kill,
  input  logic [NUM_SRC*XLEN-1:0]   rf_data,
  input  logic [DEPTH*XLEN-1:0]     stg_data,
  output logic [NUM_SRC*XLEN-1:0]   op_data,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      pc_write,
  output logic                      ifid_write,
  output logic                      idex_bubble,
  output logic                      if_flush,
  output logic [CNT_W-1:0]          stall_cnt
);

  sb_entry_t [DEPTH-1:0] entries_reg;
  sb_entry_t [DEPTH-1:0] entries_next;
  logic [CNT_W-1:0]      stall_cnt_reg;
  logic [NUM_SRC-1:0]    hit;
  logic [NUM_SRC-1:0]    rdy;
  logic [NUM_SRC-1:0]    need_stall;
  logic [1:0]            stage [NUM_SRC];

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      sb_match #(
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT)
      ) u_match (
        .src_addr (id_src_addr[gi*REG_AW +: REG_AW]),
        .src_used (id_src_used[gi]),
        .entries  (entries_reg),
        .hit      (hit[gi]),
        .stage    (stage[gi]),
        .ready    (rdy[gi])
      );

      assign need_stall[gi] = hit[gi] & ~rdy[gi];
      assign fwd_sel[gi*2 +: 2] = (hit[gi] && rdy[gi]) ? 2'(stage[gi] + 2'd1) : FWD_RF;
      assign op_data[gi*XLEN +: XLEN] = (hit[gi] && rdy[gi]) ?
                                        stg_data[stage[gi]*XLEN +: XLEN] :
                                        rf_data[gi*XLEN +: XLEN];
    end
  endgenerate

  assign stall       = |need_stall;
  assign pc_write    = ~stall;
  assign ifid_write  = ~stall;
  assign idex_bubble = stall;
  // A stalled branch re-resolves next cycle on forwarded data, so hold the flush.
  assign if_flush    = id_redirect & ~stall;
  assign stall_cnt   = stall_cnt_reg;

  always_comb begin
    entries_next = entries_reg;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      entries_next[k] = entries_reg[k-1];
    end
    entries_next[1].vld     = entries_reg[0].vld & ~ex_kill;
    entries_next[0].vld     = id_valid & id_dst_wr & (id_dst_addr != REG_ZERO) & ~stall;
    entries_next[0].dst     = id_dst_addr;
    entries_next[0].is_load = id_is_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries_reg   <= '0;
      stall_cnt_reg <= '0;
    end else begin
      entries_reg <= entries_next;
      if (stall && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
    end
  end

endmodule
